// File: rtl/urv_line_burst_slv.sv
// Memory-side slave for cache line refill/writeback bursts, backed by a word-addressed SRAM.
// Beat addresses wrap inside the line so critical-word-first refills come out in order.
module urv_line_burst_slv #(
  parameter logic [31:0] BASE_ADDR = 32'h8008_0000,
  parameter int          DEPTH_W   = 256,
  parameter int          DATA_W    = 32,
  parameter int          LINE_BYTE = 16,
  parameter int          LEN_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic                  req_wr,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  wdat_valid,
  output logic                  wdat_ready,
  input  logic [DATA_W-1:0]     wdat_data,
  input  logic [DATA_W/8-1:0]   wdat_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_last,
  output logic                  rsp_err
);

  localparam int AW = $clog2(DEPTH_W);
  localparam int OW = $clog2(LINE_BYTE / 4);
  localparam int NB = DATA_W / 8;
  localparam int CW = LEN_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_WACK = 2'd3;

  localparam logic [AW-1:0] BASE_IDX = BASE_ADDR[AW+1:2];
  localparam logic [32:0]   LIMIT    = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_W);

  logic [DATA_W-1:0] mem [DEPTH_W];

  logic [1:0]       state;
  logic [AW-1:0]    word_idx;
  logic [LEN_W-1:0] len_q;
  logic             err_q;
  logic [CW-1:0]    cnt;

  logic [OW-1:0] beat_off;
  logic [AW-1:0] beat_addr;
  logic          last_beat;
  logic          req_err;
  logic          wr_fire;
  logic          rd_issue;

  // Only the in-line offset advances; the line-base bits of the start address stay fixed.
  assign beat_off  = word_idx[OW-1:0] + OW'(cnt);
  assign beat_addr = {word_idx[AW-1:OW], beat_off};
  assign last_beat = (cnt == {1'b0, len_q});

  assign req_err    = (req_addr < BASE_ADDR) || ({1'b0, req_addr} >= LIMIT);
  assign req_ready  = (state == S_IDLE);
  assign wdat_ready = (state == S_WR);
  assign wr_fire    = wdat_valid && wdat_ready;
  assign rd_issue   = !rsp_valid || rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst && wr_fire && !err_q) begin
      for (int b = 0; b < NB; b++) begin
        if (wdat_mask[b]) mem[beat_addr][b*8 +: 8] <= wdat_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      word_idx  <= '0;
      len_q     <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            word_idx <= req_addr[AW+1:2] - BASE_IDX;
            len_q    <= req_len;
            err_q    <= req_err;
            cnt      <= '0;
            state    <= req_wr ? S_WR : S_RD;
          end
        end
        S_RD: begin
          if (rsp_valid && rsp_ready && rsp_last) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            state     <= S_IDLE;
          end else if (rd_issue) begin
            // Out-of-range bursts still return every beat, just with zero data.
            rsp_valid <= 1'b1;
            rsp_data  <= err_q ? '0 : mem[beat_addr];
            rsp_last  <= last_beat;
            rsp_err   <= err_q;
            cnt       <= cnt + 1'b1;
          end
        end
        S_WR: begin
          if (wr_fire) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              rsp_valid <= 1'b1;
              rsp_last  <= 1'b1;
              rsp_data  <= '0;
              rsp_err   <= err_q;
              state     <= S_WACK;
            end
          end
        end
        default: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_urv_line_burst_slv.sv
// Directed bench for urv_line_burst_slv: write/readback, wrapped refill, stalls,
// byte masks, out-of-range bursts and reset in the middle of a read.
module tb_urv_line_burst_slv;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wr;
  logic [1:0]  req_len;
  logic        wdat_valid;
  logic        wdat_ready;
  logic [31:0] wdat_data;
  logic [3:0]  wdat_mask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;

  int n_checks;
  int n_fail;

  urv_line_burst_slv dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_wr     (req_wr),
    .req_len    (req_len),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .wdat_data  (wdat_data),
    .wdat_mask  (wdat_mask),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_last   (rsp_last),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus_write(input logic [31:0] addr, input int len,
                                     input logic [3:0][31:0] data, input logic [3:0][3:0] mask,
                                     input logic exp_err);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wr = 1'b1; req_len = 2'(len);
    checkOutput("wr_req_ready", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      wdat_valid = 1'b1; wdat_data = data[i]; wdat_mask = mask[i];
      checkOutput("wdat_ready", {31'b0, wdat_ready}, 32'd1);
    end
    @(negedge clk);
    wdat_valid = 1'b0;
    checkOutput("wack_valid", {31'b0, rsp_valid}, 32'd1);
    checkOutput("wack_last", {31'b0, rsp_last}, 32'd1);
    checkOutput("wack_data", rsp_data, 32'd0);
    checkOutput("wack_err", {31'b0, rsp_err}, {31'b0, exp_err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("wack_done_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("wack_done_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic applyStimulus_read(input logic [31:0] addr, input int len,
                                    input logic [3:0][31:0] exp, input logic exp_err,
                                    input logic [3:0] pat);
    int beat;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_wr = 1'b0; req_len = 2'(len);
    rsp_ready = 1'b0;
    checkOutput("rd_req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rd_lat0", {31'b0, rsp_valid}, 32'd0);
    beat = 0;
    for (int k = 0; k < 40 && beat <= len; k++) begin
      @(negedge clk);
      rsp_ready = pat[k % 4];
      if (k == 0) checkOutput("rd_lat1", {31'b0, rsp_valid}, 32'd1);
      if (rsp_valid) begin
        checkOutput("rd_data", rsp_data, exp[beat]);
        checkOutput("rd_last", {31'b0, rsp_last}, {31'b0, beat == len});
        checkOutput("rd_err", {31'b0, rsp_err}, {31'b0, exp_err});
        if (rsp_ready) beat++;
      end
    end
    checkOutput("rd_beats", beat, len + 1);
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("rd_done_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rd_done_req_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_wr = 1'b0; req_len = '0;
    wdat_valid = 1'b0; wdat_data = '0; wdat_mask = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rst_wdat_ready", {31'b0, wdat_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rst_rsp_data", rsp_data, 32'd0);
    checkOutput("rst_rsp_last", {31'b0, rsp_last}, 32'd0);
    checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'd0);

    // write data presented while idle must not be accepted
    wdat_valid = 1'b1;
    @(negedge clk);
    checkOutput("idle_wdat_ready", {31'b0, wdat_ready}, 32'd0);
    wdat_valid = 1'b0;

    applyStimulus_write(32'h8008_0000, 3, {32'h44, 32'h33, 32'h22, 32'h11},
                        {4'hF, 4'hF, 4'hF, 4'hF}, 1'b0);
    applyStimulus_read(32'h8008_0000, 3, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 4'b1111);
    applyStimulus_read(32'h8008_0008, 3, {32'h22, 32'h11, 32'h44, 32'h33}, 1'b0, 4'b1111);
    // ready pattern 1,0,0,1 per cycle
    applyStimulus_read(32'h8008_0000, 3, {32'h44, 32'h33, 32'h22, 32'h11}, 1'b0, 4'b1001);

    applyStimulus_write(32'h8008_0004, 0, {32'h0, 32'h0, 32'h0, 32'hAABB_CCDD},
                        {4'h0, 4'h0, 4'h0, 4'b0101}, 1'b0);
    applyStimulus_read(32'h8008_0004, 0, {32'h0, 32'h0, 32'h0, 32'h00BB_00DD}, 1'b0, 4'b1111);

    applyStimulus_read(32'h0000_1000, 1, {32'h0, 32'h0, 32'h0, 32'h0}, 1'b1, 4'b1111);
    // 0x1000 aliases word 0 if the write were not suppressed
    applyStimulus_write(32'h0000_1000, 1, {32'h0, 32'h0, 32'hDEAD_BEEF, 32'hCAFE_F00D},
                        {4'h0, 4'h0, 4'hF, 4'hF}, 1'b1);
    applyStimulus_read(32'h8008_0000, 3, {32'h44, 32'h33, 32'h00BB_00DD, 32'h11}, 1'b0, 4'b1111);

    // reset while beat 1 of a read is being presented
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h8008_0008; req_wr = 1'b0; req_len = 2'd3;
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_beat0", rsp_data, 32'h33);
    @(negedge clk);
    checkOutput("rstmid_beat1", rsp_data, 32'h44);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; rsp_ready = 1'b0;
    checkOutput("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    checkOutput("rstmid_req_ready", {31'b0, req_ready}, 32'd1);
    checkOutput("rstmid_rsp_last", {31'b0, rsp_last}, 32'd0);
    checkOutput("rstmid_rsp_data", rsp_data, 32'd0);
    applyStimulus_read(32'h8008_000C, 1, {32'h0, 32'h0, 32'h11, 32'h44}, 1'b0, 4'b1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
